// File: rtl/tri_pkg.sv
// Shared constants, state encoding and small helpers for the triangle rasterizer.
package tri_pkg;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int CW        = 10;
  localparam int DW        = 11;
  localparam int PW        = 22;

  typedef enum logic [2:0] {
    IDLE, SETUP, EVAL0, EVAL1, EVAL2, EMIT, FIN
  } state_e;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pt_t;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [CW-1:0] clip(input logic [CW-1:0] v, input logic [CW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/tri_edge_unit.sv
// Shared edge function: lt = (ax-cx)*(by-cy) < (bx-cx)*(ay-cy), eq when both products match.
module tri_edge_unit
  import tri_pkg::*;
(
  input  pt_t  a,
  input  pt_t  b,
  input  pt_t  c,
  output logic lt,
  output logic eq
);
  logic signed [DW-1:0] dax, day, dbx, dby;
  logic signed [PW-1:0] pl, pr;

  always_comb begin
    dax = $signed({1'b0, a.x}) - $signed({1'b0, c.x});
    day = $signed({1'b0, a.y}) - $signed({1'b0, c.y});
    dbx = $signed({1'b0, b.x}) - $signed({1'b0, c.x});
    dby = $signed({1'b0, b.y}) - $signed({1'b0, c.y});
    pl  = PW'(dax) * PW'(dby);
    pr  = PW'(dbx) * PW'(day);
    lt  = pl < pr;
    eq  = pl == pr;
  end
endmodule

// File: rtl/triangle_raster_ctrl.sv
// Scans a window pixel by pixel, testing each against a latched triangle with one shared edge unit.
// Define TRI_BBOX_EN to shrink the window to the clipped vertex bounding box.
module triangle_raster_ctrl
  import tri_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] p1x,
  input  logic [CW-1:0] p1y,
  input  logic [CW-1:0] p2x,
  input  logic [CW-1:0] p2y,
  input  logic [CW-1:0] p3x,
  input  logic [CW-1:0] p3y,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          out_inside,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam logic [CW-1:0] XMAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] YMAX = CW'(V_RES - 1);

  state_e        state_q, state_d;
  pt_t           p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [CW-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          s0_q, s0_d, s1_q, s1_d, inside_q, inside_d, degen_q, degen_d;

  pt_t           ea, eb, ec, pt;
  logic          e_lt, e_eq;
  logic [CW-1:0] win_xs, win_xe, win_ys, win_ye;
  logic          last_x, last_y;

  tri_edge_unit u_edge (.a(ea), .b(eb), .c(ec), .lt(e_lt), .eq(e_eq));

  assign pt     = '{x: x_q, y: y_q};
  assign last_x = (x_q == xe_q);
  assign last_y = (y_q == ye_q);

  // SETUP reuses the edge unit on (p1,p2,p3) for the degenerate-area test
  always_comb begin
    ea = pt; eb = p1_q; ec = p2_q;
    unique case (state_q)
      SETUP:   begin ea = p1_q; eb = p2_q; ec = p3_q; end
      EVAL1:   begin eb = p2_q; ec = p3_q; end
      EVAL2:   begin eb = p3_q; ec = p1_q; end
      default: ;
    endcase
  end

  always_comb begin
`ifdef TRI_BBOX_EN
    win_xs = clip(min3(p1_q.x, p2_q.x, p3_q.x), XMAX);
    win_xe = clip(max3(p1_q.x, p2_q.x, p3_q.x), XMAX);
    win_ys = clip(min3(p1_q.y, p2_q.y, p3_q.y), YMAX);
    win_ye = clip(max3(p1_q.y, p2_q.y, p3_q.y), YMAX);
`else
    win_xs = '0;
    win_xe = XMAX;
    win_ys = '0;
    win_ye = YMAX;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = EVAL0;
      EVAL0:   state_d = EVAL1;
      EVAL1:   state_d = EVAL2;
      EVAL2:   state_d = EMIT;
      EMIT:    if (out_ready) state_d = (last_x && last_y) ? FIN : EVAL0;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE) && (state_q != FIN);
    done      = (state_q == FIN);
    out_valid = (state_q == EMIT);
  end

  always_comb begin
    p1_d = p1_q; p2_d = p2_q; p3_d = p3_q;
    xs_d = xs_q; xe_d = xe_q; ys_d = ys_q; ye_d = ye_q;
    x_d = x_q; y_d = y_q;
    s0_d = s0_q; s1_d = s1_q; inside_d = inside_q; degen_d = degen_q;
    unique case (state_q)
      IDLE: if (start) begin
        p1_d = '{x: p1x, y: p1y};
        p2_d = '{x: p2x, y: p2y};
        p3_d = '{x: p3x, y: p3y};
      end
      SETUP: begin
        xs_d = win_xs; xe_d = win_xe; ys_d = win_ys; ye_d = win_ye;
        x_d = win_xs; y_d = win_ys;
        degen_d = e_eq;
      end
      EVAL0: s0_d = e_lt;
      EVAL1: s1_d = e_lt;
      EVAL2: inside_d = (s0_q == s1_q) && (s1_q == e_lt) && !degen_q;
      EMIT: if (out_ready && !(last_x && last_y)) begin
        if (last_x) begin
          x_d = xs_q;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q <= '0; p2_q <= '0; p3_q <= '0;
      xs_q <= '0; xe_q <= '0; ys_q <= '0; ye_q <= '0;
      x_q <= '0; y_q <= '0;
      s0_q <= 1'b0; s1_q <= 1'b0; inside_q <= 1'b0; degen_q <= 1'b0;
    end else begin
      p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d;
      xs_q <= xs_d; xe_q <= xe_d; ys_q <= ys_d; ye_q <= ye_d;
      x_q <= x_d; y_q <= y_d;
      s0_q <= s0_d; s1_q <= s1_d; inside_q <= inside_d; degen_q <= degen_d;
    end
  end

  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_inside = inside_q;
endmodule

// File: tb/tb_triangle_raster_ctrl.sv
// Directed bench with a pixel scoreboard; small H_RES/V_RES keep full-window scans short.
module tb_triangle_raster_ctrl;
  localparam int H = 32;
  localparam int V = 24;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic       start, out_ready;
  logic       busy, done, out_inside, out_valid;
  logic [9:0] out_x, out_y;

  typedef struct { int x; int y; bit in; } px_t;
  px_t sb[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, pix_cnt = 0, done_cnt = 0, ins_cnt = 0;
  int in_10_10 = -1, in_20_20 = -1;

  triangle_raster_ctrl #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst(rst),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .start(start), .busy(busy), .done(done),
    .out_x(out_x), .out_y(out_y), .out_inside(out_inside),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit edge_lt(int ax, int ay, int bx, int by, int cx, int cy);
    return (ax - cx) * (by - cy) < (bx - cx) * (ay - cy);
  endfunction

  function automatic int mn(int a, int b); return a < b ? a : b; endfunction
  function automatic int mx(int a, int b); return a > b ? a : b; endfunction

  // Push every expected pixel of one triangle in raster order; returns pixel count
  task automatic push_tri(input int ax, ay, bx, by, cx, cy, output int n);
    int xs, xe, ys, ye;
    bit degen, s0, s1, s2;
    px_t p;
`ifdef TRI_BBOX_EN
    xs = mn(mn(mn(ax, bx), cx), H - 1); xe = mn(mx(mx(ax, bx), cx), H - 1);
    ys = mn(mn(mn(ay, by), cy), V - 1); ye = mn(mx(mx(ay, by), cy), V - 1);
`else
    xs = 0; xe = H - 1; ys = 0; ye = V - 1;
`endif
    degen = ((ax - cx) * (by - cy)) == ((bx - cx) * (ay - cy));
    n = 0;
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++) begin
        s0 = edge_lt(x, y, ax, ay, bx, by);
        s1 = edge_lt(x, y, bx, by, cx, cy);
        s2 = edge_lt(x, y, cx, cy, ax, ay);
        p.x = x; p.y = y; p.in = (s0 == s1) && (s1 == s2) && !degen;
        sb.push_back(p);
        n++;
      end
  endtask

  // Scoreboard pop on each accepted pixel
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        px_t e;
        e = sb.pop_front();
        chk("pix_x", 32'(out_x), 32'(e.x));
        chk("pix_y", 32'(out_y), 32'(e.y));
        chk("pix_in", 32'(out_inside), 32'(e.in));
      end
      pix_cnt++;
      if (out_inside) ins_cnt++;
      if (out_x == 10'd10 && out_y == 10'd10) in_10_10 = int'(out_inside);
      if (out_x == 10'd20 && out_y == 10'd20) in_20_20 = int'(out_inside);
    end
    if (!rst && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_tri(input int ax, ay, bx, by, cx, cy);
    p1x = 10'(ax); p1y = 10'(ay); p2x = 10'(bx); p2y = 10'(by); p3x = 10'(cx); p3y = 10'(cy);
  endtask

  task automatic pulse_start(output int s);
    tick(); start = 1'b1; s = cyc;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int s, output int lat);
    bit seen = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    lat = cyc - s;
  endtask

  initial begin
    int n, s, lat, d0, p0;
    logic [9:0] hx, hy;
    logic hi;
    bit seen;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    set_tri(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {busy, done, out_valid, out_inside, out_x, out_y}, 32'd0);

    // T1: right triangle, no stalls, exact latency
    set_tri(10, 10, 20, 10, 10, 20);
    push_tri(10, 10, 20, 10, 10, 20, n);
    d0 = done_cnt; p0 = pix_cnt;
    pulse_start(s);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", s, lat);
    chk("t1_latency", 32'(lat), 32'(4 * n + 2));
    chk("t1_busy_fin", 32'(busy), 32'd0);
    tick(); @(negedge clk);
    chk("t1_idle", {busy, done, out_valid}, 32'd0);
    chk("t1_pixels", 32'(pix_cnt - p0), 32'(n));
    chk("t1_in_10_10", 32'(in_10_10), 32'd1);
    chk("t1_in_20_20", 32'(in_20_20), 32'd0);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // T2: degenerate triangle, 7-cycle stall on first pixel, start pulsed while busy
    set_tri(5, 5, 10, 10, 15, 15);
    push_tri(5, 5, 10, 10, 15, 15, n);
    out_ready = 1'b0;
    d0 = done_cnt; p0 = pix_cnt; ins_cnt = 0;
    pulse_start(s);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    chk("t2_valid_seen", 32'(seen), 32'd1);
    hx = out_x; hy = out_y; hi = out_inside;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 2) begin start = 1'b1; set_tri(1, 2, 30, 3, 4, 20); end
      if (i == 3) start = 1'b0;
      @(negedge clk);
      chk("t2_stall_hold", {out_valid, out_inside, out_x, out_y}, {1'b1, hi, hx, hy});
    end
    tick(); out_ready = 1'b1;
    wait_done("t2", s, lat);
    tick(); repeat (3) tick();
    chk("t2_pixels", 32'(pix_cnt - p0), 32'(n));
    chk("t2_no_inside", 32'(ins_cnt), 32'd0);
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // T3: reset after 50 pixels, then restart from window origin
    set_tri(10, 10, 20, 10, 10, 20);
    push_tri(10, 10, 20, 10, 10, 20, n);
    d0 = done_cnt; p0 = pix_cnt;
    pulse_start(s);
    for (int i = 0; i < BUDGET && (pix_cnt - p0) < 50; i++) @(negedge clk);
    chk("t3_reached_50", 32'(pix_cnt - p0 >= 50), 32'd1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; sb.delete();
    @(negedge clk);
    chk("t3_rst_outs", {busy, done, out_valid, out_inside, out_x, out_y}, 32'd0);
    repeat (20) @(negedge clk);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    push_tri(10, 10, 20, 10, 10, 20, n);
    p0 = pix_cnt;
    pulse_start(s);
    wait_done("t3b", s, lat);
    chk("t3b_latency", 32'(lat), 32'(4 * n + 2));
    chk("t3b_pixels", 32'(pix_cnt - p0), 32'(n));
    chk("t3b_sb_empty", 32'(sb.size()), 32'd0);

    // T4: vertex past the right edge gets clipped
    set_tri(3, 2, 700, 5, 8, 20);
    push_tri(3, 2, 700, 5, 8, 20, n);
    p0 = pix_cnt;
    pulse_start(s);
    wait_done("t4", s, lat);
    chk("t4_pixels", 32'(pix_cnt - p0), 32'(n));
`ifndef TRI_BBOX_EN
    chk("t4_full_window", 32'(pix_cnt - p0), 32'(H * V));
`endif
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/triangle_raster_ctrl.md
TRIANGLE_RASTER_CTRL -- requirements
Module: triangle_raster_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640: horizontal scan limit in pixels.
REQ-002 SHALL have parameter V_RES, default 480: vertical scan limit in lines.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports p1x, p1y, p2x, p2y, p3x, p3y, each input, 10 bits: triangle vertices, sampled only on start acceptance.
REQ-006 SHALL have port start, input, 1 bit: request to rasterize one triangle.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after start acceptance until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse after the last pixel is accepted.
REQ-009 SHALL have ports out_x and out_y, each output, 10 bits: coordinate of the current pixel.
REQ-010 SHALL have port out_inside, output, 1 bit: pixel-in-triangle result.
REQ-011 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: valid/ready handshake for the pixel stream.

Function
REQ-012 SHALL implement states IDLE, SETUP, EVAL0, EVAL1, EVAL2, EMIT, FIN.
REQ-013 SHALL accept start only in IDLE: latch vertices, go to SETUP; start outside IDLE is ignored.
REQ-014 SHALL, in SETUP (one cycle), compute the scan window and the triangle area test, initialise x/y to the window origin, then go to EVAL0.
REQ-015 SHALL evaluate one edge per cycle on a single shared edge unit: EVAL0 (pt,p1,p2), EVAL1 (pt,p2,p3), EVAL2 (pt,p3,p1).
REQ-016 SHALL compute edge(a,b,c) as (ax-cx)*(by-cy) < (bx-cx)*(ay-cy), with differences as signed 11-bit, products as signed 22-bit and a signed compare.
REQ-017 SHALL set out_inside = (s0==s1==s2) AND NOT degenerate, where degenerate means area products are equal for (p1,p2,p3).
REQ-018 SHALL assert out_valid in EMIT only, holding out_x/out_y/out_inside stable until out_valid & out_ready.
REQ-019 SHALL, on handshake, advance raster order (x+1; at window x end, x = x start and y+1) and go to EVAL0; after the last pixel go to FIN.
REQ-020 SHALL pulse done for exactly one cycle in FIN, then return to IDLE; busy deasserts in the same cycle.
REQ-021 SHALL take 4 cycles per pixel minimum; total = 1 + 4*N + 1 cycles plus stall cycles, for N pixels.
REQ-022 SHALL permit out_ready low indefinitely without losing or altering the pending pixel.

Reset
REQ-023 SHALL, on rst, enter IDLE with busy=0, done=0, out_valid=0, out_inside=0, out_x=0, out_y=0, regardless of state.
REQ-024 SHALL abandon any in-progress triangle on rst mid-scan; no done pulse is generated for it.

Configuration
REQ-025 SHALL honour macro TRI_BBOX_EN: when defined, the window is the vertex bounding box (min/max of x and y), clipped to H_RES-1/V_RES-1.
REQ-026 SHALL, without TRI_BBOX_EN, use the window x 0..H_RES-1, y 0..V_RES-1 for every triangle.

Structure
REQ-027 SHALL place the constants H_RES/V_RES defaults, the coordinate width (10), the difference width (11) and the product width (22), and the state enumeration in shared package tri_pkg.
REQ-028 SHALL instantiate one sub-module tri_edge_unit (three points in; lt and eq out, combinational) shared across SETUP and EVAL states.

Verification
REQ-029 SHALL cover, with TRI_BBOX_EN: triangle (10,10),(20,10),(10,20), out_ready=1 -> 121 pixels, first (10,10) inside=1, (20,20) inside=0, done 486 cycles after start.
REQ-030 SHALL cover a degenerate triangle (5,5),(10,10),(15,15) -> every pixel emitted with inside=0, done pulses once.
REQ-031 SHALL cover backpressure: out_ready low for 7 cycles in EMIT -> out_x/out_y/out_inside unchanged; pixel count unchanged.
REQ-032 SHALL cover start pulsed while busy -> ignored; vertices unchanged; single done.
REQ-033 SHALL cover rst asserted at pixel 50 of a scan -> next cycle IDLE, all outputs 0, no done; new start scans from the window origin.
REQ-034 SHALL cover clipping: vertex x=700 with TRI_BBOX_EN -> window x end 639; without the macro -> 307200 pixels per triangle.
